// File: rtl/npu_pkg.sv
// Shared NPU types: accumulator/activation widths, int8 saturation bounds and
// the result-drain FSM encoding.
package npu_pkg;

  typedef logic signed [31:0] acc_t;
  typedef logic signed [7:0]  act_t;

  localparam int ACT_MAX = 127;
  localparam int ACT_MIN = -128;

  typedef enum logic {IDLE, DRAIN} drain_state_e;

endpackage

// File: rtl/requant_sat.sv
// One int32 -> int8 requant lane: round-half-up arithmetic right shift, then
// saturation to the int8 range. Purely combinational.
module requant_sat
  import npu_pkg::*;
(
  input  acc_t       x_i,
  input  logic [4:0] shift_i,
  output act_t       y_o
);

  localparam logic signed [33:0] HI = 34'(ACT_MAX);
  localparam logic signed [33:0] LO = 34'(ACT_MIN);

  // 34 bits hold x + 2^30 at the extremes without wrapping.
  logic signed [33:0] ext;
  logic signed [33:0] rnd;
  logic signed [33:0] y;

  always_comb begin
    ext = {{2{x_i[31]}}, x_i};
    rnd = '0;
    if (shift_i != 5'd0) rnd = 34'sd1 <<< (shift_i - 5'd1);
    y = (ext + rnd) >>> shift_i;
    if (y > HI)      y_o = act_t'(ACT_MAX);
    else if (y < LO) y_o = act_t'(ACT_MIN);
    else             y_o = y[7:0];
  end

endmodule

// File: rtl/result_requant_drain.sv
// Captures the NxN int32 result matrix on the multiplier's valid pulse and
// drains it as requantized int8 rows over a valid/ready stream.
module result_requant_drain
  import npu_pkg::*;
#(
  parameter  int N     = 8,
  localparam int ROW_W = $clog2(N)
) (
  input  logic                       i_clk,
  input  logic                       i_arst_n,
  input  logic [N-1:0][N-1:0][31:0]  i_c,
  input  logic                       i_validResult,
  input  logic [4:0]                 i_shift,
  output logic [N-1:0][7:0]          o_rowData,
  output logic [ROW_W-1:0]           o_rowIdx,
  output logic                       o_rowValid,
  input  logic                       i_rowReady,
  output logic                       o_rowLast,
  output logic                       o_busy,
  output logic                       o_overflow,
  input  logic                       i_clearOverflow
);

  if (N < 3 || N > 256) begin : g_bad_n
    $error("result_requant_drain: N must be in 3..256");
  end

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N - 1);

  drain_state_e            state_q, state_d;
  acc_t [N-1:0][N-1:0]     mat_q, mat_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [4:0]              shift_q, shift_d;
  logic                    ovf_q, ovf_d;

  logic xfer, xfer_last, capture, drop;

  assign xfer      = o_rowValid & i_rowReady;
  assign xfer_last = xfer & (row_q == LAST_ROW);
  // A new result is taken when idle or exactly as the last row leaves.
  assign capture   = i_validResult & ((state_q == IDLE) | xfer_last);
  assign drop      = i_validResult & ~capture;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= IDLE;
      mat_q   <= '0;
      row_q   <= '0;
      shift_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
      row_q   <= row_d;
      shift_q <= shift_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_validResult) state_d = DRAIN;
      DRAIN:   if (xfer_last && !i_validResult) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mat_d   = mat_q;
    row_d   = row_q;
    shift_d = shift_q;
    if (capture) begin
      mat_d   = i_c;
      row_d   = '0;
      shift_d = i_shift;
    end else if (xfer_last) begin
      row_d = '0;
    end else if (xfer) begin
      row_d = row_q + 1'b1;
    end
    // Set beats clear when a drop and a clear land together.
    ovf_d = drop | (ovf_q & ~i_clearOverflow);
  end

  always_comb begin
    o_rowValid = (state_q == DRAIN);
    o_busy     = (state_q == DRAIN);
    o_rowLast  = (state_q == DRAIN) & (row_q == LAST_ROW);
    o_rowIdx   = row_q;
    o_overflow = ovf_q;
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    act_t y;
    requant_sat u_rq (
      .x_i     (mat_q[row_q][k]),
      .shift_i (shift_q),
      .y_o     (y)
    );
    assign o_rowData[k] = y;
  end

endmodule

// File: doc/result_requant_drain.md
Name: result_requant_drain

Overview:
- Downstream of the NxN systolic matrix-multiply top. On the multiplier's one-cycle valid-result pulse, captures the full NxN int32 result matrix.
- Requantizes each element to int8 using a round-half-up arithmetic right shift followed by saturation.
- Drains the matrix one row per beat over a valid/ready stream into the activation buffer.
- Frees the multiplier to start its next job as soon as the result is captured.

Parameters:
- N, 8: matrix dimension; legal range 3..256, same as the multiplier. An out-of-range value is an elaboration error.
- ROW_W, $clog2(N): width of the row index (localparam).

Ports:
- i_clk  input  1  clock
- i_arst_n  input  1  asynchronous active-low reset
- i_c  input  [N-1:0][N-1:0][31:0]  result matrix from the multiplier; signed int32; i_c[r][k] is row r, column k
- i_validResult  input  1  one-cycle pulse; i_c is valid in this cycle
- i_shift  input  5  requant right-shift amount, 0..31; sampled together with i_c
- o_rowData  output  [N-1:0][7:0]  int8 row; element k is column k
- o_rowIdx  output  ROW_W  row number of the current beat
- o_rowValid  output  1  beat valid
- i_rowReady  input  1  sink ready
- o_rowLast  output  1  asserted with the beat of row N-1
- o_busy  output  1  a matrix is held or being drained
- o_overflow  output  1  sticky flag: a result arrived while busy and was dropped
- i_clearOverflow  input  1  synchronous clear of o_overflow

Behaviour:
- Reset values (async assert, sync deassert by the system):
  - state IDLE
  - o_rowValid, o_rowLast, o_busy, o_overflow all 0
  - o_rowIdx 0; o_rowData 0
  - capture buffer 0; latched shift 0
- State machine, two states:
  - IDLE -> DRAIN when i_validResult=1. In that cycle:
    - buffer <= i_c; shiftReg <= i_shift; rowIdx <= 0
    - From the next cycle: o_busy=1, o_rowValid=1.
  - DRAIN:
    - A beat transfers when o_rowValid & i_rowReady.
    - On transfer of row r < N-1: rowIdx <= r+1.
    - On transfer of row N-1: go to IDLE, and o_rowValid=0 and o_busy=0 the next cycle — unless a new capture occurs in that same cycle (see simultaneous events).
- Latency and throughput:
  - Capture to first beat valid: 1 cycle.
  - Under continuous ready, N beats on consecutive cycles.
  - Minimum period between accepted results: N+1 cycles; N cycles when a result pulse coincides with the last-row transfer.
- Stream rules:
  - While o_rowValid=1 and i_rowReady=0, o_rowData, o_rowIdx and o_rowLast hold stable.
  - o_rowValid never drops without a transfer, except on reset.
  - o_rowLast = o_rowValid & (rowIdx == N-1).
- Requant arithmetic, per element x (signed 32-bit), with s = shiftReg:
  - s = 0: y = x.
  - s > 0: y = (sext34(x) + (1 << (s-1))) >>> s, computed in 34-bit signed; no intermediate overflow is allowed.
  - Saturate: y > 127 -> 127; y < -128 -> -128; otherwise y[7:0].
  - o_rowData is the combinational function of buffer[rowIdx] and shiftReg; N element units operate in parallel.
- Simultaneous events and boundary conditions:
  - i_validResult in DRAIN, coinciding with the last-row transfer: accepted. The new matrix is captured, rowIdx <= 0, o_rowValid stays 1, o_busy stays 1, no overflow.
  - i_validResult in DRAIN at any other time: the new data is dropped, the buffer is untouched and o_overflow <= 1.
  - i_clearOverflow together with a new drop: set wins, so o_overflow stays 1.
  - i_clearOverflow alone: o_overflow <= 0 next cycle.
  - Reset mid-drain: the in-flight matrix is discarded, all outputs go to reset values and no further beats are produced.
  - Changes to i_shift outside the capture cycle have no effect.

Decomposition:
- Shared package npu_pkg:
  - typedef acc_t (logic signed [31:0]) and act_t (logic signed [7:0])
  - constants ACT_MAX=127 and ACT_MIN=-128
  - typedef drain_state_e {IDLE, DRAIN}
- One sub-module: requant_sat (purely combinational). Inputs acc_t x and the 5-bit shift; output act_t. Instantiated N times in a generate loop.

Test Plan:
- Capture and drain:
  - Stimulus: N=4, i_c[r][k] = 16*(4r+k) (values 0..240), shift=4, ready held 1.
  - Required: rows {0,1,2,3}, {4,5,6,7}, ... on 4 consecutive cycles; o_rowLast only on row 3; o_busy falls 1 cycle after the last beat.
- Rounding and saturation:
  - Stimulus: shift=2, elements {5, -6, 6, 1000}.
  - Required outputs: {1, -1, 2, 127}.
  - Further checks:
    - shift=0 with x = -200 gives -128.
    - shift=31 with x = 0x7FFFFFFF gives 1.
    - shift=31 with x = 0x80000000 gives -1.
- Backpressure:
  - Stimulus: ready=0 for 5 cycles after the first valid, then toggling 1,0,1.
  - Required: row 0 data, rowIdx and rowLast are stable throughout the stall; exactly N beats total; no duplicate or skipped row index.
- Overflow:
  - Stimulus: a second i_validResult at row 1 of a drain.
  - Required: the remaining rows still carry the first matrix; o_overflow=1 until i_clearOverflow is pulsed.
  - Also: clear and a new drop in the same cycle leaves o_overflow=1.
- Back-to-back:
  - Stimulus: i_validResult in the same cycle as the row N-1 transfer.
  - Required: o_rowValid never deasserts; the next beat is row 0 of the new matrix; o_overflow=0.
- Reset mid-drain:
  - Stimulus: assert i_arst_n=0 asynchronously during row 2.
  - Required: all outputs go to 0 immediately. After release, no beats until a new i_validResult, and the next drain starts at rowIdx 0.
